// File: rtl/genius_key_input.sv
// genius_key_input: conditions four raw active-low push-buttons into single
// registered key events for the Genius game logic.
//   CLOCK_50    system clock, rising edge
//   reset       asynchronous active-low reset
//   KEY[3:0]    raw buttons, 0 = pressed, asynchronous
//   enable      1 = press events accepted, 0 = presses discarded
//   key_ready   consumer accepts the pending event
//   clr_overrun synchronous clear of the overrun flag
//   key_valid   event pending
//   key_code    index of the pressed key
//   key_onehot  one-hot of key_code, zero while no event is pending
//   key_held    debounced pressed state per key
//   overrun     sticky: an accepted press was lost to backpressure
module genius_key_input #(
  parameter int unsigned P_KEY           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [P_KEY-1:0] KEY,
  input  logic             enable,
  input  logic             key_ready,
  input  logic             clr_overrun,
  output logic             key_valid,
  output logic [1:0]       key_code,
  output logic [P_KEY-1:0] key_onehot,
  output logic [P_KEY-1:0] key_held,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [P_KEY-1:0] sync1_q, sync2_q;
  logic [P_KEY-1:0] s;
  logic [CNT_W-1:0] cnt_q [P_KEY];
  logic [CNT_W-1:0] cnt_d [P_KEY];
  logic [P_KEY-1:0] held_q, held_d;
  logic [P_KEY-1:0] held_dly_q;
  logic [P_KEY-1:0] press;
  logic             cand;
  logic [1:0]       win_code;
  logic [P_KEY-1:0] win_onehot;

  logic             valid_q, valid_d;
  logic [1:0]       code_q, code_d;
  logic [P_KEY-1:0] onehot_q, onehot_d;
  logic             ovr_q, ovr_d;

  // Synchronized buttons, active-high
  assign s = ~sync2_q;

  // Debounce: count consecutive mismatching cycles, toggle on the last one
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < int'(P_KEY); i++) begin
      cnt_d[i] = '0;
      if (s[i] != held_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          held_d[i] = ~held_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced state; lowest index wins
  assign press = held_q & ~held_dly_q;

  always_comb begin
    win_code = '0;
    for (int i = int'(P_KEY) - 1; i >= 0; i--) begin
      if (press[i]) win_code = 2'(i);
    end
  end

  assign win_onehot = P_KEY'(1) << win_code;
  assign cand       = (|press) & enable;

  // Event register and overrun flag next state
  always_comb begin
    valid_d  = valid_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    ovr_d    = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (!valid_q || key_ready) begin
      if (cand) begin
        valid_d  = 1'b1;
        code_d   = win_code;
        onehot_d = win_onehot;
      end else if (valid_q) begin
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    end else if (cand) begin
      // Set takes priority over a same-edge clear
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      held_q     <= '0;
      held_dly_q <= '0;
      for (int i = 0; i < int'(P_KEY); i++) cnt_q[i] <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      onehot_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= KEY;
      sync2_q    <= sync1_q;
      held_q     <= held_d;
      held_dly_q <= held_q;
      for (int i = 0; i < int'(P_KEY); i++) cnt_q[i] <= cnt_d[i];
      valid_q    <= valid_d;
      code_q     <= code_d;
      onehot_q   <= onehot_d;
      ovr_q      <= ovr_d;
    end
  end

  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_onehot = onehot_q;
  assign key_held   = held_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_genius_key_input.sv
// Directed bench for genius_key_input with a short debounce window.
module tb_genius_key_input;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       enable;
  logic       key_ready;
  logic       clr_overrun;
  logic       key_valid;
  logic [1:0] key_code;
  logic [3:0] key_onehot;
  logic [3:0] key_held;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int ev0;

  genius_key_input #(
    .P_KEY(4),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .KEY(key),
    .enable(enable),
    .key_ready(key_ready),
    .clr_overrun(clr_overrun),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_onehot(key_onehot),
    .key_held(key_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Consumed events
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) ev_cnt <= ev_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; key = 4'b0000; enable = 1'b1; key_ready = 1'b1; clr_overrun = 1'b0;
    tick(3);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_code", 8'(key_code), 8'h0);
    check("rst_onehot", 8'(key_onehot), 8'h0);
    check("rst_held", 8'(key_held), 8'h0);
    check("rst_overrun", 8'(overrun), 8'h0);

    // Release reset with KEY[2] held: debounced afresh
    key = 4'b1011; rst_n = 1'b1;
    tick(5);
    check("rel_held_t5", 8'(key_held), 8'h0);
    tick(1);
    check("rel_held_t6", 8'(key_held), 8'h4);
    check("rel_valid_t6", 8'(key_valid), 8'h0);
    tick(1);
    check("rel_valid_t7", 8'(key_valid), 8'h1);
    check("rel_code_t7", 8'(key_code), 8'h2);
    check("rel_onehot_t7", 8'(key_onehot), 8'h4);
    tick(1);
    check("rel_valid_t8", 8'(key_valid), 8'h0);
    check("rel_onehot_t8", 8'(key_onehot), 8'h0);
    check("rel_code_hold", 8'(key_code), 8'h2);
    key = 4'b1111;
    tick(8);
    check("rel_release_held", 8'(key_held), 8'h0);
    check("rel_events", 8'(ev_cnt), 8'd1);

    // Bounce on KEY[1]
    ev0 = ev_cnt;
    repeat (5) begin
      key = 4'b1101; tick(2);
      key = 4'b1111; tick(2);
    end
    check("bnc_held_during", 8'(key_held), 8'h0);
    check("bnc_no_event", 8'(ev_cnt), 8'(ev0));
    key = 4'b1101;
    tick(6);
    check("bnc_held_t6", 8'(key_held), 8'h2);
    check("bnc_valid_t6", 8'(key_valid), 8'h0);
    tick(1);
    check("bnc_valid_t7", 8'(key_valid), 8'h1);
    check("bnc_code_t7", 8'(key_code), 8'h1);
    check("bnc_onehot_t7", 8'(key_onehot), 8'h2);
    tick(1);
    check("bnc_valid_t8", 8'(key_valid), 8'h0);
    repeat (5) begin
      key = 4'b1111; tick(2);
      key = 4'b1101; tick(2);
    end
    check("bnc_rel_held", 8'(key_held), 8'h2);
    key = 4'b1111;
    tick(8);
    check("bnc_rel_cleared", 8'(key_held), 8'h0);
    check("bnc_one_event", 8'(ev_cnt), 8'(ev0 + 1));

    // Backpressure and overrun
    key_ready = 1'b0;
    key = 4'b1110;
    tick(8);
    check("bp_valid", 8'(key_valid), 8'h1);
    check("bp_code", 8'(key_code), 8'h0);
    check("bp_ovr_before", 8'(overrun), 8'h0);
    key = 4'b0110;
    tick(8);
    check("bp_valid_hold", 8'(key_valid), 8'h1);
    check("bp_code_hold", 8'(key_code), 8'h0);
    check("bp_onehot_hold", 8'(key_onehot), 8'h1);
    check("bp_overrun", 8'(overrun), 8'h1);
    check("bp_held", 8'(key_held), 8'h9);
    key_ready = 1'b1;
    tick(1);
    check("bp_drop_valid", 8'(key_valid), 8'h0);
    check("bp_drop_onehot", 8'(key_onehot), 8'h0);
    check("bp_ovr_sticky", 8'(overrun), 8'h1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("bp_ovr_clr", 8'(overrun), 8'h0);
    key = 4'b1111;
    tick(8);

    // Back-to-back: consume and load on the same edge
    key_ready = 1'b0;
    key = 4'b1101;
    tick(8);
    check("b2b_first_code", 8'(key_code), 8'h1);
    key = 4'b0101;
    tick(6);
    check("b2b_held", 8'(key_held), 8'ha);
    check("b2b_valid_pre", 8'(key_valid), 8'h1);
    check("b2b_code_pre", 8'(key_code), 8'h1);
    key_ready = 1'b1;
    tick(1);
    check("b2b_valid_nogap", 8'(key_valid), 8'h1);
    check("b2b_code_next", 8'(key_code), 8'h3);
    check("b2b_onehot_next", 8'(key_onehot), 8'h8);
    check("b2b_no_ovr", 8'(overrun), 8'h0);
    tick(1);
    check("b2b_valid_end", 8'(key_valid), 8'h0);
    key = 4'b1111;
    tick(8);

    // Simultaneous press of keys 0 and 2
    ev0 = ev_cnt;
    key = 4'b1010;
    tick(6);
    check("sim_held", 8'(key_held), 8'h5);
    tick(1);
    check("sim_valid", 8'(key_valid), 8'h1);
    check("sim_code", 8'(key_code), 8'h0);
    check("sim_onehot", 8'(key_onehot), 8'h1);
    tick(1);
    check("sim_valid_end", 8'(key_valid), 8'h0);
    check("sim_no_ovr", 8'(overrun), 8'h0);
    check("sim_one_event", 8'(ev_cnt), 8'(ev0 + 1));
    key = 4'b1111;
    tick(8);

    // Enable gating
    enable = 1'b0;
    key = 4'b1101;
    tick(6);
    check("en_held", 8'(key_held), 8'h2);
    tick(2);
    check("en_no_valid", 8'(key_valid), 8'h0);
    check("en_no_ovr", 8'(overrun), 8'h0);
    enable = 1'b1;
    tick(4);
    check("en_no_late_event", 8'(key_valid), 8'h0);
    key = 4'b1111;
    tick(8);
    check("en_released", 8'(key_held), 8'h0);
    key = 4'b1101;
    tick(7);
    check("en_repress_valid", 8'(key_valid), 8'h1);
    check("en_repress_code", 8'(key_code), 8'h1);
    tick(1);
    key = 4'b1111;
    tick(8);

    // Reset mid-debounce, key still held afterwards
    key = 4'b1110;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_held", 8'(key_held), 8'h0);
    check("mid_rst_code", 8'(key_code), 8'h0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check("mid_held_t6", 8'(key_held), 8'h1);
    tick(1);
    check("mid_valid_t7", 8'(key_valid), 8'h1);
    check("mid_code_t7", 8'(key_code), 8'h0);
    key = 4'b1111;
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
